rx_multi_frame_packer: RTL and testbench

//  Multi-channel successor of the single-lane record assembler. Takes NCH streams of decoded 8b10b symbols
//  and packs each into BPW-slot words of 9 bits {k,data}. Words are tagged with their channel number and merged

---
 rtl/rx_frame_pkg.sv | 40 ++++
 rtl/rx_symbol_packer.sv | 151 +++++++++++++++
 rtl/rx_multi_frame_packer.sv | 143 ++++++++++++++
 tb/tb_rx_multi_frame_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared constants, types and helpers for the multi-channel frame packer
package rx_frame_pkg;

  localparam logic [7:0] K_SOF0 = 8'hFC;
  localparam logic [7:0] K_SOF1 = 8'hBC;
  localparam logic [7:0] K_EOF0 = 8'h5C;
  localparam logic [7:0] K_EOF1 = 8'h7C;
  localparam logic [7:0] K_IDLE = 8'h3C;
  localparam int SLOT_W = 9;
  localparam logic [SLOT_W-1:0] IDLE_SLOT = 9'h13C;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef enum logic [1:0] {CLS_DATA, CLS_SOF, CLS_EOF, CLS_IDLE} sym_class_t;
  typedef enum logic {ST_EMPTY, ST_FILL} pack_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    clog2 = r;
  endfunction

  // Unrecognised K characters fall into the idle class.
  function automatic sym_class_t classify(input logic k, input logic [7:0] d);
    if (!k)                           classify = CLS_DATA;
    else if (d == K_SOF0 || d == K_SOF1) classify = CLS_SOF;
    else if (d == K_EOF0 || d == K_EOF1) classify = CLS_EOF;
    else                              classify = CLS_IDLE;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s > 255) sat_add = 8'hFF;
    else         sat_add = s[7:0];
  endfunction

endpackage

// File: rtl/rx_symbol_packer.sv
// rtl/rx_symbol_packer.sv - per-channel slot FSM, partial word and holding register(s)
// Optional timestamp holding register under RX_FRAME_TIMESTAMP_EN.
module rx_symbol_packer
  import rx_frame_pkg::*;
#(
  parameter int BPW = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_sym_valid,
  input  logic                  i_sym_k,
  input  logic [7:0]            i_sym_data,
  input  logic                  i_sym_err,
`ifdef RX_FRAME_TIMESTAMP_EN
  input  logic [31:0]           i_timestamp,
  output logic                  o_is_ts,
`endif
  input  logic                  i_grant,
  output logic                  o_req,
  output logic [SLOT_W*BPW-1:0] o_word,
  output logic [1:0]            o_lost,
  output logic                  o_dec_err
);

  localparam int WW = SLOT_W * BPW;
  localparam int SW = clog2(BPW);

  pack_state_t   r_state, w_state_nx;
  logic [SW-1:0] r_slot, w_slot_nx;
  logic [WW-1:0] r_part, w_part_nx;
  logic          w_cmp;
  logic [WW-1:0] w_cmp_word;
  logic          r_cmp_valid;
  logic [WW-1:0] r_cmp_word;
  logic          r_hold_valid;
  logic [WW-1:0] r_hold_word;
  logic          r_dec_err;
  logic          w_acc, w_err, w_data_take;
  sym_class_t    w_cls;
  slot_t         w_sym;

  assign w_acc = i_sym_valid & i_enable & ~i_sym_err;
  assign w_err = i_sym_valid & i_enable & i_sym_err;
  assign w_cls = classify(i_sym_k, i_sym_data);
  assign w_sym = {i_sym_k, i_sym_data};

  always_comb begin
    w_state_nx = r_state;
    w_slot_nx  = r_slot;
    w_part_nx  = r_part;
    w_cmp      = 1'b0;
    w_cmp_word = r_part;
    if (!i_enable) begin
      w_state_nx = ST_EMPTY;
      w_slot_nx  = '0;
    end else if (w_acc) begin
      if (w_cls == CLS_IDLE) begin
        if (r_state == ST_FILL) begin
          for (int i = 0; i < BPW; i++) begin
            if (i >= int'(r_slot)) w_cmp_word[(BPW-1-i)*SLOT_W +: SLOT_W] = IDLE_SLOT;
          end
          w_cmp      = 1'b1;
          w_state_nx = ST_EMPTY;
          w_slot_nx  = '0;
        end
      end else begin
        for (int i = 0; i < BPW; i++) begin
          if (i == int'(r_slot)) w_cmp_word[(BPW-1-i)*SLOT_W +: SLOT_W] = w_sym;
        end
        if (int'(r_slot) == BPW - 1) begin
          w_cmp      = 1'b1;
          w_state_nx = ST_EMPTY;
          w_slot_nx  = '0;
        end else begin
          w_part_nx  = w_cmp_word;
          w_state_nx = ST_FILL;
          w_slot_nx  = r_slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_EMPTY;
      r_slot       <= '0;
      r_part       <= '0;
      r_cmp_valid  <= 1'b0;
      r_cmp_word   <= '0;
      r_hold_valid <= 1'b0;
      r_hold_word  <= '0;
      r_dec_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_slot      <= w_slot_nx;
      r_part      <= w_part_nx;
      r_cmp_valid <= w_cmp;
      r_cmp_word  <= w_cmp_word;
      r_dec_err   <= w_err;
      // A word granted away this cycle frees the register for the new one.
      if (r_cmp_valid && (!r_hold_valid || w_data_take)) begin
        r_hold_valid <= 1'b1;
        r_hold_word  <= r_cmp_word;
      end else if (w_data_take) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign o_lost[0] = r_cmp_valid & r_hold_valid & ~w_data_take;
  assign o_dec_err = r_dec_err;

`ifdef RX_FRAME_TIMESTAMP_EN
  logic          r_ts_valid;
  logic [WW-1:0] r_ts_word;
  logic          r_ts_lost;
  logic          w_sof, w_ts_take;

  assign w_sof       = w_acc & (w_cls == CLS_SOF);
  assign w_ts_take   = i_grant & r_ts_valid;
  assign w_data_take = i_grant & ~r_ts_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ts_valid <= 1'b0;
      r_ts_word  <= '0;
      r_ts_lost  <= 1'b0;
    end else begin
      r_ts_lost <= w_sof & r_ts_valid & ~w_ts_take;
      if (w_sof && (!r_ts_valid || w_ts_take)) begin
        r_ts_valid <= 1'b1;
        r_ts_word  <= WW'(i_timestamp);
      end else if (w_ts_take) begin
        r_ts_valid <= 1'b0;
      end
    end
  end

  assign o_req     = r_hold_valid | r_ts_valid;
  assign o_is_ts   = r_ts_valid;
  assign o_word    = r_ts_valid ? r_ts_word : r_hold_word;
  assign o_lost[1] = r_ts_lost;
`else
  assign w_data_take = i_grant;
  assign o_req       = r_hold_valid;
  assign o_word      = r_hold_word;
  assign o_lost[1]   = 1'b0;
`endif

endmodule

// File: rtl/rx_multi_frame_packer.sv
// rtl/rx_multi_frame_packer.sv - round-robin merge of per-channel packed words into one FWFT FIFO
// RX_FRAME_TIMESTAMP_EN adds the TIMESTAMP input and a timestamp-word flag on OUT_DATA.
module rx_multi_frame_packer
  import rx_frame_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int BPW   = 3,
  parameter int DEPTH = 16,
  localparam int CHW  = (NCH > 1) ? clog2(NCH) : 1,
  localparam int LW   = clog2(DEPTH) + 1,
`ifdef RX_FRAME_TIMESTAMP_EN
  localparam int W    = 1 + CHW + SLOT_W * BPW
`else
  localparam int W    = CHW + SLOT_W * BPW
`endif
) (
  input  logic             WCLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   ENABLE,
  input  logic [NCH-1:0]   SYM_VALID,
  input  logic [NCH-1:0]   SYM_K,
  input  logic [8*NCH-1:0] SYM_DATA,
  input  logic [NCH-1:0]   SYM_ERR,
`ifdef RX_FRAME_TIMESTAMP_EN
  input  logic [31:0]      TIMESTAMP,
`endif
  output logic [W-1:0]     OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [LW-1:0]    FIFO_LEVEL,
  output logic [7:0]       LOST_ERR_CNT,
  output logic [7:0]       DEC_ERR_CNT
);

  localparam int WW = SLOT_W * BPW;
  localparam int AW = clog2(DEPTH);

  logic [NCH-1:0] w_req, w_grant, w_dec_err;
  logic [WW-1:0]  w_word [NCH];
  logic [1:0]     w_lost [NCH];
  logic           w_any, w_full, w_push, w_pop;
  logic [CHW-1:0] w_gnt_idx;
  logic [CHW-1:0] r_ptr;
  logic [W-1:0]   w_push_data;
  logic [W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [LW-1:0]  r_level;
  int             w_lost_sum, w_err_sum;
`ifdef RX_FRAME_TIMESTAMP_EN
  logic [NCH-1:0] w_is_ts;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rx_symbol_packer #(.BPW(BPW)) u_packer (
      .i_clk       (WCLK),
      .i_rst       (RESET),
      .i_enable    (ENABLE[g]),
      .i_sym_valid (SYM_VALID[g]),
      .i_sym_k     (SYM_K[g]),
      .i_sym_data  (SYM_DATA[8*g +: 8]),
      .i_sym_err   (SYM_ERR[g]),
`ifdef RX_FRAME_TIMESTAMP_EN
      .i_timestamp (TIMESTAMP),
      .o_is_ts     (w_is_ts[g]),
`endif
      .i_grant     (w_grant[g]),
      .o_req       (w_req[g]),
      .o_word      (w_word[g]),
      .o_lost      (w_lost[g]),
      .o_dec_err   (w_dec_err[g])
    );
  end

  // First requester at or after the pointer wins; nothing is granted into a full FIFO.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    if (!w_full) begin
      for (int i = 0; i < NCH; i++) begin
        v_idx = (int'(r_ptr) + i) % NCH;
        if (!w_any && w_req[v_idx]) begin
          w_any     = 1'b1;
          w_gnt_idx = CHW'(v_idx);
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      w_grant[i] = w_any && (w_gnt_idx == CHW'(i));
    end
  end

`ifdef RX_FRAME_TIMESTAMP_EN
  assign w_push_data = {w_is_ts[w_gnt_idx], w_gnt_idx, w_word[w_gnt_idx]};
`else
  assign w_push_data = {w_gnt_idx, w_word[w_gnt_idx]};
`endif

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_push     = w_any;
  assign w_pop      = OUT_VALID & OUT_READY;
  assign OUT_VALID  = (r_level != '0);
  assign OUT_DATA   = r_mem[r_rd];
  assign FIFO_LEVEL = r_level;

  always_comb begin
    w_lost_sum = 0;
    w_err_sum  = 0;
    for (int i = 0; i < NCH; i++) begin
      w_lost_sum = w_lost_sum + int'(w_lost[i][0]) + int'(w_lost[i][1]);
      w_err_sum  = w_err_sum + int'(w_dec_err[i]);
    end
  end

  always_ff @(posedge WCLK) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      r_ptr        <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      LOST_ERR_CNT <= '0;
      DEC_ERR_CNT  <= '0;
    end else begin
      if (w_any) r_ptr <= (int'(w_gnt_idx) == NCH - 1) ? '0 : w_gnt_idx + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      LOST_ERR_CNT <= sat_add(LOST_ERR_CNT, w_lost_sum);
      DEC_ERR_CNT  <= sat_add(DEC_ERR_CNT, w_err_sum);
    end
  end

endmodule

// File: tb/tb_rx_multi_frame_packer.sv
// tb/tb_rx_multi_frame_packer.sv - directed table-driven bench for rx_multi_frame_packer (NCH=4, BPW=3)
module tb_rx_multi_frame_packer;

  localparam int NCH = 4;
  localparam int BPW = 3;
  localparam int DEPTH = 16;
`ifdef RX_FRAME_TIMESTAMP_EN
  localparam int W = 1 + 2 + 9 * BPW;
`else
  localparam int W = 2 + 9 * BPW;
`endif

  logic             WCLK = 1'b0;
  logic             RESET;
  logic [NCH-1:0]   ENABLE, SYM_VALID, SYM_K, SYM_ERR;
  logic [8*NCH-1:0] SYM_DATA;
  logic [W-1:0]     OUT_DATA;
  logic             OUT_VALID, OUT_READY;
  logic [4:0]       FIFO_LEVEL;
  logic [7:0]       LOST_ERR_CNT, DEC_ERR_CNT;
`ifdef RX_FRAME_TIMESTAMP_EN
  logic [31:0]      TIMESTAMP = 32'h0;
`endif

  rx_multi_frame_packer #(.NCH(NCH), .BPW(BPW), .DEPTH(DEPTH)) dut (
    .WCLK(WCLK), .RESET(RESET), .ENABLE(ENABLE), .SYM_VALID(SYM_VALID), .SYM_K(SYM_K),
    .SYM_DATA(SYM_DATA), .SYM_ERR(SYM_ERR),
`ifdef RX_FRAME_TIMESTAMP_EN
    .TIMESTAMP(TIMESTAMP),
`endif
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .FIFO_LEVEL(FIFO_LEVEL), .LOST_ERR_CNT(LOST_ERR_CNT), .DEC_ERR_CNT(DEC_ERR_CNT)
  );

  always #5 WCLK = ~WCLK;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int           ch;
    int           n;
    logic [35:0]  syms;
    logic         has;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs [8];
  logic [W-1:0] exp4 [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge WCLK);
    #1;
  endtask

  task automatic idle_inputs();
    SYM_VALID = '0;
    SYM_K     = '0;
    SYM_DATA  = '0;
    SYM_ERR   = '0;
  endtask

  task automatic drive(input int ch, input logic [8:0] s, input logic err);
    SYM_VALID[ch]       = 1'b1;
    SYM_K[ch]           = s[8];
    SYM_DATA[8*ch +: 8] = s[7:0];
    SYM_ERR[ch]         = err;
  endtask

  task automatic send(input int ch, input logic [8:0] s);
    idle_inputs();
    drive(ch, s, 1'b0);
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  function automatic logic [W-1:0] mkw(input int ch, input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    mkw = W'({2'(ch), a, b, c});
  endfunction

  function automatic logic [8:0] bsym(input int b, input int c, input int j);
    if (j == 0)      bsym = {1'b0, 8'(b * 16 + c)};
    else if (j == 1) bsym = {1'b0, 8'(8'h80 + c)};
    else             bsym = {1'b0, 8'(b)};
  endfunction

  task automatic burst(input int b);
    for (int j = 0; j < 3; j++) begin
      idle_inputs();
      for (int c = 0; c < NCH; c++) drive(c, bsym(b, c, j), 1'b0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int idx;
    int extra;
    vecs[0] = '{1, 2, {9'h0AA, 9'h13C, 9'h000, 9'h000}, 1'b1, mkw(1, 9'h0AA, 9'h13C, 9'h13C)};
    vecs[1] = '{2, 1, {9'h13C, 9'h000, 9'h000, 9'h000}, 1'b0, '0};
    vecs[2] = '{3, 3, {9'h15C, 9'h010, 9'h020, 9'h000}, 1'b1, mkw(3, 9'h15C, 9'h010, 9'h020)};
    vecs[3] = '{0, 3, {9'h011, 9'h17C, 9'h1BC, 9'h000}, 1'b1, mkw(0, 9'h011, 9'h17C, 9'h1BC)};
    vecs[4] = '{2, 3, {9'h055, 9'h066, 9'h1F7, 9'h000}, 1'b1, mkw(2, 9'h055, 9'h066, 9'h13C)};
    vecs[5] = '{1, 2, {9'h000, 9'h1FF, 9'h000, 9'h000}, 1'b1, mkw(1, 9'h000, 9'h13C, 9'h13C)};
    vecs[6] = '{0, 4, {9'h13C, 9'h012, 9'h034, 9'h056}, 1'b1, mkw(0, 9'h012, 9'h034, 9'h056)};
    vecs[7] = '{3, 2, {9'h13C, 9'h13C, 9'h000, 9'h000}, 1'b0, '0};
    for (int b = 0; b < 5; b++)
      for (int c = 0; c < NCH; c++)
        exp4[b*4+c] = mkw(c, bsym(b, c, 0), bsym(b, c, 1), bsym(b, c, 2));

    ENABLE = '1;
    OUT_READY = 1'b0;
    do_reset();
    check("rst_valid", OUT_VALID, 0);
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_lost", LOST_ERR_CNT, 0);
    check("rst_dec", DEC_ERR_CNT, 0);

    send(0, 9'h1FC); send(0, 9'h001); send(0, 9'h002);
    tick();
    check("lat_valid_t1", OUT_VALID, 0);
    tick();
    check("lat_valid_t2", OUT_VALID, 1);
    check("lat_data", OUT_DATA, mkw(0, 9'h1FC, 9'h001, 9'h002));
    pop();
    check("lat_empty", OUT_VALID, 0);

    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < vecs[v].n; j++) send(vecs[v].ch, vecs[v].syms[35-9*j -: 9]);
      tick(); tick();
      check($sformatf("vec%0d_valid", v), OUT_VALID, vecs[v].has);
      if (vecs[v].has) begin
        check($sformatf("vec%0d_data", v), OUT_DATA, vecs[v].exp);
        pop();
      end
    end

    do_reset();
    burst(5);
    tick(); tick();
    check("rr_level_t2", FIFO_LEVEL, 1);
    tick(); tick(); tick();
    check("rr_level_t5", FIFO_LEVEL, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr0_word%0d", i), OUT_DATA, mkw(i, bsym(5, i, 0), bsym(5, i, 1), bsym(5, i, 2)));
      pop();
    end
    send(1, 9'h021); send(1, 9'h022); send(1, 9'h023);
    tick(); tick();
    check("rr_single", OUT_DATA, mkw(1, 9'h021, 9'h022, 9'h023));
    pop();
    burst(6);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr2_word%0d", i), OUT_DATA,
            mkw((i + 2) % 4, bsym(6, (i + 2) % 4, 0), bsym(6, (i + 2) % 4, 1), bsym(6, (i + 2) % 4, 2)));
      pop();
    end

    do_reset();
    for (int b = 0; b < 5; b++) begin
      burst(b);
      tick(); tick(); tick();
    end
    send(0, 9'h0EE); send(0, 9'h0EF); send(0, 9'h0F0);
    tick(); tick(); tick();
    check("full_level", FIFO_LEVEL, 16);
    check("lost_one", LOST_ERR_CNT, 1);
    for (int k = 0; k < 75; k++) burst(7);
    tick(); tick(); tick();
    check("lost_sat", LOST_ERR_CNT, 8'hFF);
    check("lost_dec_zero", DEC_ERR_CNT, 0);
    OUT_READY = 1'b1;
    idx = 0;
    extra = 0;
    for (int cy = 0; cy < 60; cy++) begin
      if (OUT_VALID) begin
        if (idx < 20) check($sformatf("drain%0d", idx), OUT_DATA, exp4[idx]);
        else extra++;
        idx++;
      end
      tick();
    end
    OUT_READY = 1'b0;
    check("drain_count", idx, 20);
    check("drain_extra", extra, 0);

    do_reset();
    send(2, 9'h011);
    idle_inputs(); drive(2, 9'h022, 1'b1); tick(); idle_inputs();
    send(2, 9'h033); send(2, 9'h044);
    tick(); tick();
    check("err_word", OUT_DATA, mkw(2, 9'h011, 9'h033, 9'h044));
    check("dec_one", DEC_ERR_CNT, 1);
    pop();
    idle_inputs();
    drive(0, 9'h001, 1'b1); drive(1, 9'h002, 1'b1); drive(3, 9'h003, 1'b1);
    tick(); idle_inputs();
    tick(); tick();
    check("dec_four", DEC_ERR_CNT, 4);
    check("err_no_word", OUT_VALID, 0);
    send(1, 9'h001); send(1, 9'h002);
    ENABLE[1] = 1'b0; tick(); ENABLE[1] = 1'b1;
    send(1, 9'h003);
    tick(); tick(); tick();
    check("en_drop_no_word", OUT_VALID, 0);
    send(1, 9'h004); send(1, 9'h005);
    tick(); tick();
    check("en_drop_word", OUT_DATA, mkw(1, 9'h003, 9'h004, 9'h005));
    pop();
    send(3, 9'h031); send(3, 9'h032); send(3, 9'h033);
    tick(); tick();
    check("pre_rst_valid", OUT_VALID, 1);
    send(0, 9'h0A1);
    do_reset();
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_level", FIFO_LEVEL, 0);
    check("mid_rst_dec", DEC_ERR_CNT, 0);
    check("mid_rst_lost", LOST_ERR_CNT, 0);
    send(0, 9'h00A); send(0, 9'h00B); send(0, 9'h00C);
    tick(); tick();
    check("post_rst_word", OUT_DATA, mkw(0, 9'h00A, 9'h00B, 9'h00C));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
